// File: rtl/menu_select_gen.sv
// VGA menu overlay: passes timing through with one cycle of delay, draws the frame border
// and N_ITEMS stacked boxes, and tracks an up/down/ok selection for game control.
module menu_select_gen #(
    parameter int          N_ITEMS   = 4,
    parameter int          H_ACTIVE  = 1024,
    parameter int          V_ACTIVE  = 768,
    parameter int          BOX_X     = 362,
    parameter int          BOX_W     = 313,
    parameter int          BOX_Y0    = 46,
    parameter int          BOX_H     = 101,
    parameter int          BOX_PITCH = 192,
    parameter bit          WRAP      = 1'b1,
    parameter logic [11:0] C_BLANK   = 12'h333,
    parameter logic [11:0] C_BORDER  = 12'hfff,
    parameter logic [11:0] C_HILITE  = 12'hff0,
    parameter logic [11:0] C_FILL    = 12'h0f0
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [10:0] vcount_in,
    input  logic [10:0] hcount_in,
    input  logic        vsync_in,
    input  logic        hsync_in,
    input  logic        vblnk_in,
    input  logic        hblnk_in,
    input  logic        menu_en,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_ok,
    output logic [10:0] vcount_out,
    output logic [10:0] hcount_out,
    output logic        vsync_out,
    output logic        hsync_out,
    output logic        vblnk_out,
    output logic        hblnk_out,
    output logic [11:0] rgb_out,
    output logic [2:0]  sel_idx,
    output logic        confirm,
    output logic        confirmed
);

    typedef enum logic [1:0] {IDLE, BROWSE, CONFIRMED} state_t;
    typedef enum logic [1:0] {MV_NONE, MV_UP, MV_DOWN} move_t;

    localparam logic [2:0]  LAST   = 3'(N_ITEMS - 1);
    localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
    localparam logic [10:0] V_LAST = 11'(V_ACTIVE - 1);
    localparam logic [10:0] LEFT   = 11'(BOX_X);
    localparam logic [10:0] RIGHT  = 11'(BOX_X + BOX_W - 1);

    state_t      state;
    move_t       pending;
    move_t       new_move;
    logic        up_prev, down_prev, ok_prev, vblnk_prev;
    logic        up_ev, down_ev, ok_ev, vblnk_rise;
    logic [2:0]  sel_up, sel_down, sel_applied;
    logic [7:0]  box_outline, box_inner;
    logic [11:0] rgb_nxt;

    assign up_ev      = btn_up & ~up_prev;
    assign down_ev    = btn_down & ~down_prev;
    assign ok_ev      = btn_ok & ~ok_prev;
    assign vblnk_rise = vblnk_in & ~vblnk_prev;

    assign sel_up   = (sel_idx == 3'd0) ? (WRAP ? LAST : 3'd0) : sel_idx - 3'd1;
    assign sel_down = (sel_idx == LAST) ? (WRAP ? 3'd0 : LAST) : sel_idx + 3'd1;

    // Simultaneous up and down presses cancel and leave the pending move alone.
    always_comb begin
        new_move = MV_NONE;
        if (up_ev && !down_ev)
            new_move = MV_UP;
        else if (down_ev && !up_ev)
            new_move = MV_DOWN;
    end

    always_comb begin
        sel_applied = sel_idx;
        case (pending)
            MV_UP:   sel_applied = sel_up;
            MV_DOWN: sel_applied = sel_down;
            default: sel_applied = sel_idx;
        endcase
    end

    // Unused box slots stay zero so the selection can index the full 8-bit vectors.
    for (genvar k = 0; k < 8; k++) begin : g_box
        if (k < N_ITEMS) begin : g_used
            localparam logic [10:0] TOP = 11'(BOX_Y0 + k * BOX_PITCH);
            localparam logic [10:0] BOT = 11'(BOX_Y0 + k * BOX_PITCH + BOX_H - 1);
            logic in_rect, on_edge;
            assign in_rect = (vcount_in >= TOP) && (vcount_in <= BOT) &&
                             (hcount_in >= LEFT) && (hcount_in <= RIGHT);
            assign on_edge = (vcount_in == TOP) || (vcount_in == BOT) ||
                             (hcount_in == LEFT) || (hcount_in == RIGHT);
            assign box_outline[k] = in_rect && on_edge;
            assign box_inner[k]   = in_rect && !on_edge;
        end else begin : g_unused
            assign box_outline[k] = 1'b0;
            assign box_inner[k]   = 1'b0;
        end
    end

    always_comb begin
        rgb_nxt = 12'h000;
        if (vblnk_in || hblnk_in)
            rgb_nxt = C_BLANK;
        else if (vcount_in == 11'd0 || vcount_in == V_LAST ||
                 hcount_in == 11'd0 || hcount_in == H_LAST)
            rgb_nxt = C_BORDER;
        else if (state != IDLE && |box_outline)
            rgb_nxt = box_outline[sel_idx] ? C_HILITE : C_BLANK;
        else if (state == CONFIRMED && box_inner[sel_idx])
            rgb_nxt = C_FILL;
    end

    // Selection only moves at the start of vertical blanking so a frame never shows two choices.
    always_ff @(posedge pclk) begin
        if (rst) begin
            vcount_out <= '0;
            hcount_out <= '0;
            vsync_out  <= 1'b0;
            hsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            rgb_out    <= '0;
            sel_idx    <= '0;
            confirm    <= 1'b0;
            confirmed  <= 1'b0;
            state      <= IDLE;
            pending    <= MV_NONE;
            up_prev    <= 1'b0;
            down_prev  <= 1'b0;
            ok_prev    <= 1'b0;
            vblnk_prev <= 1'b0;
        end else begin
            vcount_out <= vcount_in;
            hcount_out <= hcount_in;
            vsync_out  <= vsync_in;
            hsync_out  <= hsync_in;
            vblnk_out  <= vblnk_in;
            hblnk_out  <= hblnk_in;
            rgb_out    <= rgb_nxt;
            up_prev    <= btn_up;
            down_prev  <= btn_down;
            ok_prev    <= btn_ok;
            vblnk_prev <= vblnk_in;
            confirm    <= 1'b0;
            if (!menu_en) begin
                state     <= IDLE;
                sel_idx   <= '0;
                pending   <= MV_NONE;
                confirmed <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= BROWSE;
                        pending <= MV_NONE;
                    end
                    BROWSE: begin
                        if (ok_ev) begin
                            state     <= CONFIRMED;
                            confirm   <= 1'b1;
                            confirmed <= 1'b1;
                            pending   <= MV_NONE;
                        end else if (vblnk_rise) begin
                            sel_idx <= sel_applied;
                            pending <= new_move;
                        end else if (new_move != MV_NONE) begin
                            pending <= new_move;
                        end
                    end
                    CONFIRMED: begin
                        pending <= MV_NONE;
                    end
                    default: begin
                        state   <= IDLE;
                        sel_idx <= '0;
                        pending <= MV_NONE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_menu_select_gen.sv
// Directed bench for menu_select_gen: a wrapping instance and a saturating instance share
// one stimulus stream; pixel colours and selection are checked against hand-computed values.
module tb_menu_select_gen;

    logic        pclk = 1'b0;
    logic        rst;
    logic [10:0] vcount_in, hcount_in;
    logic        vsync_in, hsync_in, vblnk_in, hblnk_in;
    logic        menu_en, btn_up, btn_down, btn_ok;

    logic [10:0] vcount_out, hcount_out;
    logic        vsync_out, hsync_out, vblnk_out, hblnk_out;
    logic [11:0] rgb_out;
    logic [2:0]  sel_idx;
    logic        confirm, confirmed;

    logic [10:0] s_vcount_out, s_hcount_out;
    logic        s_vsync_out, s_hsync_out, s_vblnk_out, s_hblnk_out;
    logic [11:0] s_rgb_out;
    logic [2:0]  s_sel_idx;
    logic        s_confirm, s_confirmed;

    int checks_total  = 0;
    int checks_passed = 0;

    always #5 pclk = ~pclk;

    menu_select_gen dut (
        .pclk(pclk), .rst(rst),
        .vcount_in(vcount_in), .hcount_in(hcount_in),
        .vsync_in(vsync_in), .hsync_in(hsync_in), .vblnk_in(vblnk_in), .hblnk_in(hblnk_in),
        .menu_en(menu_en), .btn_up(btn_up), .btn_down(btn_down), .btn_ok(btn_ok),
        .vcount_out(vcount_out), .hcount_out(hcount_out),
        .vsync_out(vsync_out), .hsync_out(hsync_out), .vblnk_out(vblnk_out), .hblnk_out(hblnk_out),
        .rgb_out(rgb_out), .sel_idx(sel_idx), .confirm(confirm), .confirmed(confirmed)
    );

    menu_select_gen #(.WRAP(1'b0)) dut_sat (
        .pclk(pclk), .rst(rst),
        .vcount_in(vcount_in), .hcount_in(hcount_in),
        .vsync_in(vsync_in), .hsync_in(hsync_in), .vblnk_in(vblnk_in), .hblnk_in(hblnk_in),
        .menu_en(menu_en), .btn_up(btn_up), .btn_down(btn_down), .btn_ok(btn_ok),
        .vcount_out(s_vcount_out), .hcount_out(s_hcount_out),
        .vsync_out(s_vsync_out), .hsync_out(s_hsync_out), .vblnk_out(s_vblnk_out), .hblnk_out(s_hblnk_out),
        .rgb_out(s_rgb_out), .sel_idx(s_sel_idx), .confirm(s_confirm), .confirmed(s_confirmed)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks_total++;
        if (actual === expected)
            checks_passed++;
        else
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read at the same offset.
    task automatic applyStimulus(input int h, input int v, input logic hb, input logic vb);
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hblnk_in  = hb;
        vblnk_in  = vb;
        @(posedge pclk);
        #1;
    endtask

    task automatic checkPixel(input string tag, input int h, input int v, input logic [11:0] exp_rgb);
        applyStimulus(h, v, 1'b0, 1'b0);
        checkOutput(tag, 64'(rgb_out), 64'(exp_rgb));
    endtask

    task automatic pressButton(input logic up, input logic down, input logic ok);
        btn_up   = up;
        btn_down = down;
        btn_ok   = ok;
        applyStimulus(500, 300, 1'b0, 1'b0);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_ok   = 1'b0;
        applyStimulus(500, 301, 1'b0, 1'b0);
    endtask

    task automatic frameEdge();
        applyStimulus(0, 768, 1'b0, 1'b1);
        applyStimulus(10, 5, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; menu_en = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; btn_ok = 1'b0;
        vsync_in = 1'b1; hsync_in = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(500, 300, 1'b0, 1'b0);
        checkOutput("reset_outputs", 64'({vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out,
                    hblnk_out, rgb_out, sel_idx, confirm, confirmed}), 64'd0);
        checkOutput("reset_outputs_sat", 64'({s_vcount_out, s_hcount_out, s_vsync_out, s_hsync_out,
                    s_vblnk_out, s_hblnk_out, s_rgb_out, s_sel_idx, s_confirm, s_confirmed}), 64'd0);

        rst = 1'b0; vsync_in = 1'b0; hsync_in = 1'b1;
        applyStimulus(0, 0, 1'b0, 1'b0);
        checkOutput("border_origin", 64'(rgb_out), 64'hfff);
        checkOutput("timing_passthru_a", 64'({vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out}),
                    64'({11'd0, 11'd0, 1'b0, 1'b1, 1'b0, 1'b0}));
        vsync_in = 1'b1; hsync_in = 1'b0;
        applyStimulus(123, 456, 1'b1, 1'b0);
        checkOutput("timing_passthru_b", 64'({vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out}),
                    64'({11'd456, 11'd123, 1'b1, 1'b0, 1'b0, 1'b1}));
        checkOutput("hblank_colour", 64'(rgb_out), 64'h333);
        vsync_in = 1'b0; hsync_in = 1'b0;
        checkPixel("idle_no_box", 362, 46, 12'h000);

        menu_en = 1'b1;
        applyStimulus(10, 5, 1'b0, 1'b0);
        checkPixel("box0_selected", 362, 46, 12'hff0);
        checkPixel("box1_unselected", 362, 238, 12'h333);
        checkPixel("box0_inside", 500, 100, 12'h000);
        checkPixel("box0_corner_br", 674, 146, 12'hff0);
        checkPixel("outside_box0", 675, 146, 12'h000);
        checkPixel("border_right", 1023, 400, 12'hfff);
        checkPixel("border_bottom", 400, 767, 12'hfff);
        applyStimulus(362, 46, 1'b0, 1'b1);
        checkOutput("vblank_colour", 64'(rgb_out), 64'h333);
        applyStimulus(10, 5, 1'b0, 1'b0);
        checkOutput("sel_initial", 64'(sel_idx), 64'd0);

        pressButton(1'b0, 1'b1, 1'b0);
        checkOutput("sel_midframe_hold", 64'(sel_idx), 64'd0);
        applyStimulus(0, 768, 1'b0, 1'b1);
        checkOutput("sel_after_down", 64'(sel_idx), 64'd1);
        checkPixel("box1_selected", 362, 238, 12'hff0);
        checkPixel("box0_now_unsel", 362, 46, 12'h333);

        pressButton(1'b1, 1'b0, 1'b0);
        frameEdge();
        checkOutput("sel_up_to_0", 64'(sel_idx), 64'd0);
        pressButton(1'b1, 1'b0, 1'b0);
        frameEdge();
        checkOutput("wrap_up", 64'(sel_idx), 64'd3);
        checkOutput("sat_up", 64'(s_sel_idx), 64'd0);
        pressButton(1'b0, 1'b1, 1'b0);
        frameEdge();
        checkOutput("wrap_down", 64'(sel_idx), 64'd0);
        checkOutput("sat_down", 64'(s_sel_idx), 64'd1);

        pressButton(1'b1, 1'b0, 1'b0);
        pressButton(1'b0, 1'b1, 1'b0);
        frameEdge();
        checkOutput("pending_overwrite", 64'(sel_idx), 64'd1);
        checkOutput("pending_overwrite_sat", 64'(s_sel_idx), 64'd2);

        pressButton(1'b0, 1'b1, 1'b0);
        pressButton(1'b1, 1'b1, 1'b0);
        frameEdge();
        checkOutput("up_down_cancel", 64'(sel_idx), 64'd2);
        checkOutput("up_down_cancel_sat", 64'(s_sel_idx), 64'd3);

        btn_up = 1'b1;
        for (int i = 0; i < 100; i++)
            applyStimulus(10, 5 + i, 1'b0, (i == 30 || i == 60));
        btn_up = 1'b0;
        frameEdge();
        checkOutput("held_one_move", 64'(sel_idx), 64'd1);
        checkOutput("held_one_move_sat", 64'(s_sel_idx), 64'd2);

        pressButton(1'b0, 1'b1, 1'b0);
        frameEdge();
        checkOutput("sel_before_ok", 64'(sel_idx), 64'd2);
        pressButton(1'b1, 1'b0, 1'b0);
        btn_ok = 1'b1;
        applyStimulus(0, 768, 1'b0, 1'b1);
        btn_ok = 1'b0;
        checkOutput("confirm_pulse", 64'({confirm, confirmed}), 64'b11);
        checkOutput("ok_beats_apply", 64'(sel_idx), 64'd2);
        checkOutput("ok_beats_apply_sat", 64'({s_sel_idx, s_confirmed}), 64'({3'd3, 1'b1}));
        applyStimulus(10, 5, 1'b0, 1'b0);
        checkOutput("confirm_one_cycle", 64'({confirm, confirmed}), 64'b01);
        checkPixel("box2_filled", 500, 480, 12'h0f0);
        checkPixel("box2_outline", 362, 430, 12'hff0);
        checkPixel("box0_not_filled", 500, 100, 12'h000);

        pressButton(1'b1, 1'b0, 1'b0);
        btn_ok = 1'b1;
        applyStimulus(500, 300, 1'b0, 1'b0);
        btn_ok = 1'b0;
        checkOutput("ok_ignored", 64'(confirm), 64'd0);
        frameEdge();
        checkOutput("up_ignored", 64'({sel_idx, confirmed}), 64'({3'd2, 1'b1}));

        menu_en = 1'b0;
        applyStimulus(10, 5, 1'b0, 1'b0);
        checkOutput("menu_off_state", 64'({sel_idx, confirm, confirmed}), 64'd0);
        checkPixel("idle_no_fill", 500, 480, 12'h000);
        checkPixel("idle_no_outline", 362, 430, 12'h000);
        checkPixel("idle_border", 0, 400, 12'hfff);

        menu_en = 1'b1;
        applyStimulus(10, 5, 1'b0, 1'b0);
        pressButton(1'b0, 1'b1, 1'b0);
        frameEdge();
        checkOutput("reenter_down", 64'(sel_idx), 64'd1);
        rst = 1'b1;
        applyStimulus(500, 300, 1'b0, 1'b0);
        checkOutput("midframe_reset", 64'({vcount_out, hcount_out, rgb_out, sel_idx, confirm, confirmed}), 64'd0);
        rst = 1'b0;
        applyStimulus(10, 5, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/menu_select_gen.md
Name: menu_select_gen

Overview:
- Parametrised successor of the static menu pattern generator; sits in the VGA pipeline between the timing generator and the next overlay stage.
- Passes timing through with 1-cycle latency and draws the frame border plus N_ITEMS vertically stacked menu boxes.
- Adds a selection state machine driven by pre-debounced up/down/ok buttons. It highlights the selected box, fills it on confirm and reports the chosen item to game control.

Parameters:
- N_ITEMS, 4, number of menu boxes (1..8)
- H_ACTIVE, 1024, active pixels per line
- V_ACTIVE, 768, active lines per frame
- BOX_X, 362, left column of every box
- BOX_W, 313, box width in pixels (right column = BOX_X+BOX_W-1)
- BOX_Y0, 46, top row of box 0
- BOX_H, 101, box height in lines
- BOX_PITCH, 192, vertical distance between box tops
- WRAP, 1, 1 = selection wraps at ends, 0 = saturates
- C_BLANK, 12'h333, colour during blanking and of unselected outlines
- C_BORDER, 12'hfff, frame border colour
- C_HILITE, 12'hff0, outline colour of the selected box
- C_FILL, 12'h0f0, interior fill colour of the confirmed box

Ports:
- pclk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- vcount_in  in  11  vertical counter
- hcount_in  in  11  horizontal counter
- vsync_in, hsync_in, vblnk_in, hblnk_in  in  1 each  timing signals
- menu_en  in  1  menu active; low = clear selection and stop drawing boxes
- btn_up, btn_down, btn_ok  in  1 each  debounced levels, synchronous to pclk
- vcount_out, hcount_out  out  11 each  timing delayed by 1 cycle
- vsync_out, hsync_out, vblnk_out, hblnk_out  out  1 each  timing delayed by 1 cycle
- rgb_out  out  12  pixel colour
- sel_idx  out  3  current selection
- confirm  out  1  one-cycle pulse on confirm
- confirmed  out  1  level, high in CONFIRMED state

Behaviour:
- Reset (rst synchronous, active-high; clock pclk):
  - all outputs go to 0 on the next edge;
  - state = IDLE, sel = 0, button edge registers = 0, pending = none;
  - reset mid-frame has the same effect.
- Latency: all timing outputs and rgb_out are exactly 1 pclk behind the inputs. There is no other pipeline depth.
- Button edges: each button is registered, and event = level & ~prev, giving one event per press.
- Pending move register: holds at most one up or down move.
  - A new up or down event overwrites the pending move.
  - up and down events in the same cycle cancel each other; pending is unchanged.
- State IDLE:
  - draw border and blanking only;
  - move to BROWSE when menu_en = 1.
- State BROWSE:
  - The pending move is applied on the cycle where vblnk_in rises (0 to 1), then pending is cleared. The selection never changes mid-frame.
  - Up: sel = sel-1. At sel = 0 the result is N_ITEMS-1 if WRAP=1, otherwise it stays 0.
  - Down: sel = sel+1. At sel = N_ITEMS-1 the result is 0 if WRAP=1, otherwise it stays N_ITEMS-1.
  - An ok event moves to CONFIRMED immediately and pulses confirm for 1 cycle with sel_idx stable. ok wins over a same-cycle vblnk apply, and the pending move is discarded.
- State CONFIRMED:
  - confirmed = 1; up, down and ok are ignored;
  - when menu_en = 0, move to IDLE with sel = 0.
- menu_en = 0 in any state: next state is IDLE, sel = 0, pending cleared.
- Pixel priority, highest first:
  1. blanking (vblnk_in|hblnk_in) gives C_BLANK;
  2. vcount 0 or V_ACTIVE-1, or hcount 0 or H_ACTIVE-1, gives C_BORDER;
  3. outline of box k gives C_HILITE if k = sel and state is not IDLE, otherwise C_BLANK;
  4. interior of box sel in CONFIRMED gives C_FILL;
  5. everything else gives 12'h000.
- Box k geometry:
  - top = BOX_Y0+k*BOX_PITCH, bottom = top+BOX_H-1;
  - outline = rows top and bottom across columns BOX_X..BOX_X+BOX_W-1, plus columns BOX_X and BOX_X+BOX_W-1 across rows top..bottom;
  - interior = strictly inside the outline.
- Boxes are not drawn in IDLE.
- Geometry comparisons use 11-bit unsigned arithmetic. Parameters must keep every box inside the active area; this is not checked in hardware.

Test Plan:
- Reset held 3 cycles mid-line → all outputs 0. After release, the timing outputs equal the inputs delayed 1 cycle, and rgb at (0,0) = fff.
- menu_en=1, no buttons, defaults → pixel (362,46) = ff0 (box 0 selected); (362,238) = 333; (500,100) = 000; blanking = 333.
- btn_down pulse mid-frame → sel_idx stays 0 until the vblnk rise, then becomes 1. Next frame, (362,238) = ff0 and (362,46) = 333.
- WRAP=1, sel=0, btn_up → sel=3 after the vblnk rise. With WRAP=0 the same stimulus keeps sel=0.
- up and down in the same cycle → no change. A button held high for 100 cycles → exactly one move.
- sel=2, btn_ok → confirm high for exactly 1 cycle and confirmed=1. (500,480) = 0f0. Later up/ok presses are ignored. Dropping menu_en → IDLE, sel=0, boxes no longer drawn.
